keypad_interface: RTL and testbench

KEYPAD_INTERFACE -- requirements
Module: keypad_interface

---
 rtl/keypad_pkg.sv | 57 +++++
 rtl/keypad_debounce.sv | 54 +++++
 rtl/keypad_interface.sv | 147 ++++++++++++++
 tb/tb_keypad_interface.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Keypad scanner shared definitions: FSM encoding, key codes,
// default timing and small decode helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    WAIT_RELEASE
  } state_t;

  localparam int SCAN_CYCLES_DEF     = 1000;
  localparam int DEBOUNCE_CYCLES_DEF = 20000;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // True when exactly one row is pulled low.
  function automatic logic one_low(input logic [3:0] r);
    return $onehot(~r);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] r);
    if (!r[0]) return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else return 2'd3;
  endfunction

  // r0: 1 2 3 A / r1: 4 5 6 B / r2: 7 8 9 C / r3: * 0 # D
  function automatic logic [3:0] key_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] k;
    k = '0;
    if (row == 2'd3) begin
      unique case (col)
        2'd0:    k = KEY_STAR;
        2'd1:    k = 4'd0;
        2'd2:    k = KEY_HASH;
        default: k = KEY_D;
      endcase
    end else if (col == 2'd3) begin
      k = KEY_A + {2'b00, row};
    end else begin
      k = {2'b00, row} * 4'd3
        + {2'b00, col} + 4'd1;
    end
    return k;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Row synchronizer and stable-sample counter.
// Ports: filas in; enable/capture/release_mode ctrl; rows, stable_press, stable_release, lost out.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] filas,
  input  logic       enable,
  input  logic       capture,
  input  logic       release_mode,
  output logic [3:0] rows,
  output logic       stable_press,
  output logic       stable_release,
  output logic       lost
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    meta;
  logic [3:0]    pattern;
  logic [CW-1:0] count;
  logic          match;
  logic          at_last;

  // Press tracks the captured pattern; release waits for all rows high.
  assign match = release_mode ? (rows == 4'hF)
                              : (rows == pattern);
  assign at_last = match && (count == LAST);

  assign stable_press   = enable && !release_mode && at_last;
  assign stable_release = enable && release_mode && at_last;
  assign lost           = enable && !release_mode && !match;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta    <= 4'hF;
      rows    <= 4'hF;
      pattern <= 4'hF;
      count   <= '0;
    end else begin
      meta <= filas;
      rows <= meta;
      if (capture) pattern <= rows;
      // Any break in the run, or leaving the tracking states, restarts it.
      if (enable && match) count <= count + 1'b1;
      else count <= '0;
    end
  end

endmodule

// File: rtl/keypad_interface.sv
// 4x4 matrix keypad scanner with PIN strobes and decimal amount accumulator.
// Ports: FILAS in, COLUMNAS out, MODO_MONTO in; DIGITO/MONTO/TIPO_TRANS levels and strobes out.
module keypad_interface
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = SCAN_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  FILAS,
  output logic [3:0]  COLUMNAS,
  input  logic        MODO_MONTO,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic        ENTER_PIN,
  output logic        ERASE_PIN,
  output logic        TIPO_TRANS,
  output logic [31:0] MONTO,
  output logic        MONTO_STB
);

  localparam int SW = $clog2(SCAN_CYCLES + 1);
  localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_CYCLES - 1);

  state_t        state;
  logic [1:0]    col;
  logic [1:0]    row_idx;
  logic [SW-1:0] dwell;

  logic [3:0]  rows;
  logic        stable_press;
  logic        stable_release;
  logic        lost;
  logic        dwell_end;
  logic        capture;
  logic [1:0]  next_col;
  logic [3:0]  next_drive;
  logic [3:0]  key;
  logic [35:0] next_monto;
  logic        fits;

  assign dwell_end  = (state == SCAN) && (dwell == DWELL_LAST);
  assign capture    = dwell_end && one_low(rows);
  assign next_col   = col + 2'd1;
  assign next_drive = ~(4'b0001 << next_col);
  assign key        = key_code(row_idx, col);

  // Wide enough that MONTO*10+9 never wraps before the range check.
  assign next_monto = {4'b0000, MONTO} * 36'd10
                    + {32'd0, key};
  assign fits = (next_monto[35:32] == 4'd0);

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk           (clk),
    .reset         (reset),
    .filas         (FILAS),
    .enable        ((state == DEBOUNCE) ||
                    (state == WAIT_RELEASE)),
    .capture       (capture),
    .release_mode  (state == WAIT_RELEASE),
    .rows          (rows),
    .stable_press  (stable_press),
    .stable_release(stable_release),
    .lost          (lost)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= SCAN;
      col        <= 2'd0;
      row_idx    <= 2'd0;
      dwell      <= '0;
      COLUMNAS   <= 4'b1110;
      DIGITO     <= 4'd0;
      DIGITO_STB <= 1'b0;
      ENTER_PIN  <= 1'b0;
      ERASE_PIN  <= 1'b0;
      TIPO_TRANS <= 1'b0;
      MONTO      <= 32'd0;
      MONTO_STB  <= 1'b0;
    end else begin
      DIGITO_STB <= 1'b0;
      ENTER_PIN  <= 1'b0;
      ERASE_PIN  <= 1'b0;
      MONTO_STB  <= 1'b0;
      unique case (state)
        SCAN: begin
          if (dwell_end) begin
            dwell <= '0;
            if (capture) begin
              state   <= DEBOUNCE;
              row_idx <= row_index(rows);
            end else begin
              col      <= next_col;
              COLUMNAS <= next_drive;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        DEBOUNCE: begin
          // Column stays frozen; a failed press rescans the same column.
          if (stable_press) state <= EMIT;
          else if (lost) state <= SCAN;
        end
        EMIT: begin
          state <= WAIT_RELEASE;
          unique case (1'b1)
            (key <= 4'd9): begin
              if (!MODO_MONTO) begin
                DIGITO     <= key;
                DIGITO_STB <= 1'b1;
              end else if (fits) begin
                MONTO     <= next_monto[31:0];
                MONTO_STB <= 1'b1;
                DIGITO    <= key;
              end
            end
            (key == KEY_A): begin
              ENTER_PIN <= 1'b1;
              if (MODO_MONTO) MONTO <= 32'd0;
            end
            (key == KEY_B): begin
              ERASE_PIN <= 1'b1;
              MONTO     <= 32'd0;
            end
            (key == KEY_C): TIPO_TRANS <= 1'b0;
            (key == KEY_D): TIPO_TRANS <= 1'b1;
            default: ;
          endcase
        end
        WAIT_RELEASE: begin
          if (stable_release) begin
            state    <= SCAN;
            col      <= next_col;
            COLUMNAS <= next_drive;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_interface.sv
// Directed bench for keypad_interface with a behavioural keypad matrix.
// Table of press/release vectors plus bounce, ghost and reset sequences.
module tb_keypad_interface;

  localparam int SC = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  filas;
  logic [3:0]  columnas;
  logic        modo;
  logic [3:0]  digito;
  logic        digito_stb;
  logic        enter_pin;
  logic        erase_pin;
  logic        tipo;
  logic [31:0] monto;
  logic        monto_stb;

  // pressed[c*4+r]: key at row r, column c is closed.
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;
  int n_dig  = 0;
  int n_mon  = 0;
  int n_ent  = 0;
  int n_era  = 0;
  int n_excl = 0;

  always #5 clk = ~clk;

  keypad_interface #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .FILAS     (filas),
    .COLUMNAS  (columnas),
    .MODO_MONTO(modo),
    .DIGITO    (digito),
    .DIGITO_STB(digito_stb),
    .ENTER_PIN (enter_pin),
    .ERASE_PIN (erase_pin),
    .TIPO_TRANS(tipo),
    .MONTO     (monto),
    .MONTO_STB (monto_stb)
  );

  always_comb begin
    filas = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !columnas[c])
          filas[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (digito_stb) n_dig++;
    if (monto_stb) n_mon++;
    if (enter_pin) n_ent++;
    if (erase_pin) n_era++;
    if ($countones({digito_stb, monto_stb,
                    enter_pin, erase_pin}) > 1)
      n_excl++;
  end

  typedef struct {
    int          row;
    int          col;
    bit          modo;
    logic [31:0] strb;
    logic [3:0]  dig;
    logic [31:0] mon;
    bit          tipo;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(int r, int c, bit m,
                              logic [31:0] s, logic [3:0] d,
                              logic [31:0] mo, bit t);
    vec_t x;
    x.row = r; x.col = c; x.modo = m;
    x.strb = s; x.dig = d; x.mon = mo; x.tipo = t;
    return x;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int r, input int c);
    pressed[c*4+r] = 1'b1;
    idle(40);
    pressed[c*4+r] = 1'b0;
    idle(30);
  endtask

  function automatic logic [31:0] deltas(int d, int m, int e, int r);
    return {8'(n_dig-d), 8'(n_mon-m), 8'(n_ent-e), 8'(n_era-r)};
  endfunction

  int d0, m0, e0, r0;

  initial begin
    reset   = 1'b0;
    modo    = 1'b0;
    pressed = '0;

    // strb = {digito, monto, enter, erase} pulse counts per tap
    v.push_back(mk(1,1,0,32'h01000000,4'd5,32'd0,0));
    v.push_back(mk(0,0,1,32'h00010000,4'd1,32'd1,0));
    v.push_back(mk(0,1,1,32'h00010000,4'd2,32'd12,0));
    v.push_back(mk(1,1,1,32'h00010000,4'd5,32'd125,0));
    v.push_back(mk(0,3,1,32'h00000100,4'd5,32'd0,0));
    v.push_back(mk(1,0,1,32'h00010000,4'd4,32'd4,0));
    v.push_back(mk(0,1,1,32'h00010000,4'd2,32'd42,0));
    v.push_back(mk(2,2,1,32'h00010000,4'd9,32'd429,0));
    v.push_back(mk(1,0,1,32'h00010000,4'd4,32'd4294,0));
    v.push_back(mk(2,2,1,32'h00010000,4'd9,32'd42949,0));
    v.push_back(mk(1,2,1,32'h00010000,4'd6,32'd429496,0));
    v.push_back(mk(2,0,1,32'h00010000,4'd7,32'd4294967,0));
    v.push_back(mk(0,1,1,32'h00010000,4'd2,32'd42949672,0));
    v.push_back(mk(2,2,1,32'h00010000,4'd9,32'd429496729,0));
    v.push_back(mk(1,2,1,32'h00000000,4'd9,32'd429496729,0));
    v.push_back(mk(1,1,1,32'h00010000,4'd5,32'hFFFFFFFF,0));
    v.push_back(mk(3,3,1,32'h00000000,4'd5,32'hFFFFFFFF,1));
    v.push_back(mk(1,3,0,32'h00000001,4'd5,32'd0,1));
    v.push_back(mk(2,3,0,32'h00000000,4'd5,32'd0,0));
    v.push_back(mk(3,0,0,32'h00000000,4'd5,32'd0,0));
    v.push_back(mk(3,1,0,32'h01000000,4'd0,32'd0,0));
    v.push_back(mk(3,2,1,32'h00000000,4'd0,32'd0,0));
    v.push_back(mk(3,1,1,32'h00010000,4'd0,32'd0,0));
    v.push_back(mk(3,3,0,32'h00000000,4'd0,32'd0,1));
    v.push_back(mk(2,1,1,32'h00010000,4'd8,32'd8,1));

    idle(3);
    check("rst_col", 64'(columnas), 64'(4'b1110));
    check("rst_dig", 64'(digito), 64'd0);
    check("rst_mon", 64'(monto), 64'd0);
    check("rst_tipo", 64'(tipo), 64'd0);
    check("rst_stb", 64'({digito_stb, monto_stb,
                          enter_pin, erase_pin}), 64'd0);
    reset = 1'b1;
    idle(4);
    check("scan_adv", 64'(columnas), 64'(4'b1101));
    idle(20);

    foreach (v[i]) begin
      modo = v[i].modo;
      d0 = n_dig; m0 = n_mon; e0 = n_ent; r0 = n_era;
      tap(v[i].row, v[i].col);
      check($sformatf("v%0d_strb", i),
            64'(deltas(d0, m0, e0, r0)), 64'(v[i].strb));
      check($sformatf("v%0d_dig", i), 64'(digito), 64'(v[i].dig));
      check($sformatf("v%0d_mon", i), 64'(monto), 64'(v[i].mon));
      check($sformatf("v%0d_tipo", i), 64'(tipo), 64'(v[i].tipo));
    end

    // Ghost: rows 0 and 2 closed on column 0 together.
    modo = 1'b0;
    d0 = n_dig; m0 = n_mon; e0 = n_ent; r0 = n_era;
    pressed[0] = 1'b1;
    pressed[2] = 1'b1;
    idle(60);
    pressed = '0;
    idle(30);
    check("ghost_strb", 64'(deltas(d0, m0, e0, r0)), 64'd0);
    check("ghost_dig", 64'(digito), 64'd8);

    // Bounce: key 7 chatters every 3 cycles, then released.
    d0 = n_dig; m0 = n_mon; e0 = n_ent; r0 = n_era;
    for (int k = 0; k < 10; k++) begin
      pressed[2] = ~pressed[2];
      idle(3);
    end
    pressed = '0;
    idle(30);
    check("bounce_strb", 64'(deltas(d0, m0, e0, r0)), 64'd0);
    check("bounce_mon", 64'(monto), 64'd8);

    // Reset four cycles into the debounce of key 7.
    d0 = n_dig; m0 = n_mon; e0 = n_ent; r0 = n_era;
    reset = 1'b0;
    pressed[2] = 1'b1;
    idle(2);
    reset = 1'b1;
    idle(7);
    reset = 1'b0;
    idle(2);
    pressed = '0;
    idle(1);
    check("mid_col", 64'(columnas), 64'(4'b1110));
    check("mid_dig", 64'(digito), 64'd0);
    check("mid_mon", 64'(monto), 64'd0);
    check("mid_tipo", 64'(tipo), 64'd0);
    reset = 1'b1;
    idle(40);
    check("mid_strb", 64'(deltas(d0, m0, e0, r0)), 64'd0);

    check("one_hot_stb", 64'(n_excl), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
